vga_line_fetch: RTL and testbench
=================================

Name: vga_line_fetch

Overview:
- Pixel source for the 800x600@72 Hz VGA timing generator: 50 MHz pixel clock, 1040 x 666 total, 3-bit RGB.
- Fetches each upcoming visible line from an external frame memory over a single-outstanding read handshake into a ping-pong line buffer.
- Streams the buffered pixels to the VGA pins in step with the timing generator's counters.
- Also delays the timing generator's sync outputs so colour and sync stay aligned at the connector.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_TOTAL, 1040, clocks per line
- V_ACTIVE, 600, visible lines per frame
- V_TOTAL, 666, lines per frame
- WORDS_PER_LINE, 100, memory words per line (H_ACTIVE/8)
- ADDR_W, 16, memory word address width

Ports:
- CLOCK_50  in  1  system/pixel clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- hcount  in  11  horizontal counter from timing generator (0..1039)
- vcount  in  10  vertical counter from timing generator (0..665)
- hs_in  in  1  VGA_HS from timing generator (active low)
- vs_in  in  1  VGA_VS from timing generator (active low)
- rd_req  out  1  memory read request
- rd_addr  out  ADDR_W  word address, valid while rd_req high
- rd_ack  in  1  memory accepted request this cycle
- rd_valid  in  1  rd_data valid this cycle
- rd_data  in  24  8 pixels; bits [3k+2:3k] = {R,G,B} of pixel k, k=0 leftmost
- VGA_RED  out  1  red
- VGA_GREEN  out  1  green
- VGA_BLUE  out  1  blue
- VGA_HS  out  1  hs_in delayed 2 clocks
- VGA_VS  out  1  vs_in delayed 2 clocks
- underrun  out  1  sticky: a line fetch did not complete in time

Behaviour:
- Line buffers:
  - Two banks of 100 x 24 bits.
  - The bank indexed by vcount[0] is read for display.
  - The bank indexed by target[0] is written by the fetch logic.
- Fetch trigger:
  - Fires on the cycle where hcount==0.
  - target = (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - A fetch starts only if target < V_ACTIVE.
  - Lines 0..598 prefetch lines 1..599; line 665 prefetches line 0.
- Fetch FSM:
  - IDLE: on trigger, latch target, word index w=0 → REQ.
  - REQ: rd_req=1, rd_addr = target*100 + w. Hold both stable until rd_ack; on rd_ack → DATA (rd_req low the next cycle).
  - DATA: on rd_valid, write rd_data to bank[target[0]][w]. If w==99 → IDLE, otherwise w+1 → REQ.
  - At most one request outstanding at any time.
  - rd_valid is ignored in IDLE and REQ.
- Overrun:
  - If the trigger fires while the FSM is not IDLE: set underrun=1 (sticky until RESET).
  - Abandon the current fetch and start the new target at w=0 on the same cycle.
  - Unwritten words keep stale contents.
- Arithmetic:
  - target*100 + w is computed at ADDR_W bits; maximum 59999, no overflow.
  - Word select = hcount[9:3] (0..99 in the active region).
  - Pixel select = hcount[2:0].
- Display pipeline (fixed 2-cycle latency):
  - Stage 1 registers: bank read, pixel index, active = (hcount<H_ACTIVE && vcount<V_ACTIVE), hs_in, vs_in.
  - Stage 2 registers: RGB = active ? pixel bits : 3'b000, plus VGA_HS and VGA_VS.
  - Inputs sampled at cycle t appear on the outputs at t+2.
- Simultaneous events:
  - Bank write and display read target different banks, so no collision while fetches complete in time.
  - After an overrun, the written bank may equal the displayed bank; the read returns old data (read-before-write).
- Reset (synchronous):
  - rd_req=0, rd_addr=0, FSM=IDLE, underrun=0.
  - VGA_RED/GREEN/BLUE=0; VGA_HS=1 and VGA_VS=1 (inactive).
  - Pipeline registers are cleared.
  - Buffer contents are not cleared.
  - Reset mid-fetch: rd_req low on the cycle after RESET is sampled; late rd_valid is ignored.

Test Plan:
- Memory model with 1-cycle ack and 2-cycle valid; pixel value = word address mod 8 → at vcount=0, hcount=0 the fetch issues rd_addr 100..199; on line 1, RGB at hcount=h equals (100 + h/8) mod 8, appearing 2 clocks after hcount=h; underrun stays 0.
- hcount=800..1039 and vcount=600..665 → RGB=000 at the output 2 clocks later; VGA_HS/VGA_VS equal hs_in/vs_in delayed exactly 2 clocks.
- vcount=665, hcount=0 → fetch of rd_addr 0..99; vcount=599 → no rd_req issued.
- Memory stalls rd_ack for 20 cycles per word (line fetch exceeds 1040 clocks) → underrun rises at the next hcount==0; the new fetch restarts at target*100; rd_req never has two outstanding requests.
- Assert RESET with rd_req high at w=37 → rd_req=0 the next clock; RGB=000, HS/VS=1; a stray rd_valid after reset causes no buffer write; normal fetch resumes at the next trigger.
- Hold rd_ack low for 5 cycles in REQ → rd_addr stays stable throughout; the buffer word is written only on rd_valid.

Source files
------------

// File: rtl/vga_line_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_fetch_if
// Description : Single-outstanding read bus between the VGA line fetcher
//               (master) and the external frame memory (slave).
//                 rd_req   master -> slave  request pending
//                 rd_addr  master -> slave  word address, valid with rd_req
//                 rd_ack   slave  -> master request accepted this cycle
//                 rd_valid slave  -> master rd_data valid this cycle
//                 rd_data  slave  -> master 8 pixels x 3-bit RGB
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_line_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [23:0]       rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_valid,
    output rd_data
  );
endinterface
`default_nettype wire

// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_fetch
// Description : Pixel source for an 800x600@72Hz VGA timing generator.
//               Prefetches the next visible line from frame memory into a
//               ping-pong line buffer, streams buffered pixels to the VGA
//               pins with a fixed 2-clock latency and delays the sync inputs
//               by the same amount so colour and sync stay aligned.
// Ports       : CLOCK_50           pixel clock, rising edge
//               RESET              synchronous, active-high
//               hcount / vcount    timing generator counters
//               hs_in / vs_in      timing generator syncs (active low)
//               mem_bus            read master towards frame memory
//               VGA_RED/GREEN/BLUE colour outputs
//               VGA_HS / VGA_VS    syncs delayed 2 clocks
//               underrun           sticky: a line fetch did not finish in time
// Revision    : 1.0 - initial release
// ============================================================================
module vga_line_fetch #(
  parameter int H_ACTIVE       = 800,
  parameter int H_TOTAL        = 1040,
  parameter int V_ACTIVE       = 600,
  parameter int V_TOTAL        = 666,
  parameter int WORDS_PER_LINE = 100,
  parameter int ADDR_W         = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic [$clog2(H_TOTAL)-1:0] hcount,
  input  logic [$clog2(V_TOTAL)-1:0] vcount,
  input  logic                       hs_in,
  input  logic                       vs_in,
  vga_line_fetch_if.master           mem_bus,
  output logic                       VGA_RED,
  output logic                       VGA_GREEN,
  output logic                       VGA_BLUE,
  output logic                       VGA_HS,
  output logic                       VGA_VS,
  output logic                       underrun
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int WW = $clog2(WORDS_PER_LINE);

  localparam logic [HW-1:0] c_h_active  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] c_v_active  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_v_last    = VW'(V_TOTAL - 1);
  localparam logic [WW-1:0] c_words     = WW'(WORDS_PER_LINE);
  localparam logic [WW-1:0] c_last_word = WW'(WORDS_PER_LINE - 1);

  // Fetch state machine encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;

  // --------------------------------------------------------------------------
  // Ping-pong line buffer: bank = line parity
  // --------------------------------------------------------------------------
  logic [23:0] r_buf [0:1][0:WORDS_PER_LINE-1];

  // --------------------------------------------------------------------------
  // Fetch control
  // --------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [VW-1:0] r_target;
  logic [WW-1:0] r_word;
  logic          r_underrun;

  logic [VW-1:0] w_target;
  logic          w_trigger;
  logic          w_buf_we;

  // The line after the last line of the frame is line 0 of the next frame.
  assign w_target  = (vcount == c_v_last) ? '0 : vcount + 1'b1;
  assign w_trigger = (hcount == '0) && (w_target < c_v_active);

  // A trigger on the same cycle as rd_valid abandons that word, so the
  // stale beat of the old line is not written.
  assign w_buf_we  = (r_state == c_st_data) && mem_bus.rd_valid && !w_trigger;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state    <= c_st_idle;
      r_target   <= '0;
      r_word     <= '0;
      r_underrun <= 1'b0;
    end else if (w_trigger) begin
      // A trigger while still busy means the previous line never finished;
      // flag it and restart immediately on the new line.
      if (r_state != c_st_idle) begin
        r_underrun <= 1'b1;
      end
      r_target <= w_target;
      r_word   <= '0;
      r_state  <= c_st_req;
    end else begin
      case (r_state)
        c_st_req: begin
          if (mem_bus.rd_ack) begin
            r_state <= c_st_data;
          end
        end
        c_st_data: begin
          if (mem_bus.rd_valid) begin
            if (r_word == c_last_word) begin
              r_state <= c_st_idle;
            end else begin
              r_word  <= r_word + 1'b1;
              r_state <= c_st_req;
            end
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Request and address are decoded from registered state, so they are
  // glitch-free and hold steady for as long as REQ waits for rd_ack.
  assign mem_bus.rd_req  = (r_state == c_st_req);
  assign mem_bus.rd_addr = ADDR_W'(r_target) * ADDR_W'(WORDS_PER_LINE)
                         + ADDR_W'(r_word);

  assign underrun = r_underrun;

  // Buffer write port. Contents deliberately survive reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET && w_buf_we) begin
      r_buf[r_target[0]][r_word] <= mem_bus.rd_data;
    end
  end

  // --------------------------------------------------------------------------
  // Display pipeline, stage 1: buffer read and qualifiers
  // --------------------------------------------------------------------------
  logic [WW-1:0] w_rd_idx;
  logic [23:0]   r_s1_word;
  logic [2:0]    r_s1_pix;
  logic          r_s1_active;
  logic          r_s1_hs;
  logic          r_s1_vs;

  // In the blanking interval hcount[9:3] can exceed the line length; clamp it
  // to keep the read in range (the result is masked to black anyway).
  assign w_rd_idx = (hcount[9:3] < c_words) ? hcount[9:3] : '0;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_s1_word   <= '0;
      r_s1_pix    <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
    end else begin
      // Non-blocking read of the display bank gives read-before-write
      // behaviour if the fetcher writes the same bank after an overrun.
      r_s1_word   <= r_buf[vcount[0]][w_rd_idx];
      r_s1_pix    <= hcount[2:0];
      r_s1_active <= (hcount < c_h_active) && (vcount < c_v_active);
      r_s1_hs     <= hs_in;
      r_s1_vs     <= vs_in;
    end
  end

  // --------------------------------------------------------------------------
  // Display pipeline, stage 2: pixel select, blanking and sync alignment
  // --------------------------------------------------------------------------
  logic [2:0] w_pix [0:7];

  for (genvar k = 0; k < 8; k++) begin : g_pix
    assign w_pix[k] = r_s1_word[3*k +: 3];
  end

  logic [2:0] r_rgb;
  logic       r_hs;
  logic       r_vs;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_rgb <= 3'b000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= r_s1_active ? w_pix[r_s1_pix] : 3'b000;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign VGA_RED   = r_rgb[2];
  assign VGA_GREEN = r_rgb[1];
  assign VGA_BLUE  = r_rgb[0];
  assign VGA_HS    = r_hs;
  assign VGA_VS    = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_line_fetch
// Description : Self-checking bench for vga_line_fetch. Drives the timing
//               counters directly, models the frame memory and predicts the
//               VGA outputs from a line-level model of the two buffer banks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_line_fetch;

  localparam int ADDR_W = 16;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic [10:0] hcount   = '0;
  logic [9:0]  vcount   = '0;
  logic        hs_in    = 1'b1;
  logic        vs_in    = 1'b1;
  logic        VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, underrun;

  vga_line_fetch_if #(.ADDR_W(ADDR_W)) mem_bus ();

  vga_line_fetch dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .hcount    (hcount),
    .vcount    (vcount),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .mem_bus   (mem_bus),
    .VGA_RED   (VGA_RED),
    .VGA_GREEN (VGA_GREEN),
    .VGA_BLUE  (VGA_BLUE),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .underrun  (underrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  // Frame memory contents and model of what each buffer bank holds
  logic [23:0] mem_arr  [0:59999];
  logic [23:0] ref_bank [0:1][0:99];
  bit          ref_valid [0:1];

  // Memory model knobs and statistics
  int ack_stall      = 1;
  int stray_cnt      = 0;
  int delivered      = 0;
  int req_cycles     = 0;
  int req_while_busy = 0;
  int addr_changes   = 0;
  int ack_q [$];

  // Output expected for the cycle currently visible at the pins
  logic [2:0] last_rgb = 3'b000;
  logic       last_hs  = 1'b1;
  logic       last_vs  = 1'b1;
  bit         last_chk = 1'b1;
  int         last_h   = 0;
  int         last_v   = 0;

  // --------------------------------------------------------------------------
  // Frame memory: ack after ack_stall waiting cycles, data 2 cycles after ack,
  // one request in service at a time.
  // --------------------------------------------------------------------------
  initial begin : responder
    int vcnt;
    int waitc;
    bit busy;
    int lat;
    int since_trig;
    logic [ADDR_W-1:0] prev_addr;
    vcnt = 0; waitc = 0; busy = 0; lat = 0; since_trig = 100; prev_addr = '0;
    mem_bus.rd_ack   = 1'b0;
    mem_bus.rd_valid = 1'b0;
    mem_bus.rd_data  = '0;
    forever begin
      @(posedge CLOCK_50);
      #2;
      mem_bus.rd_ack   = 1'b0;
      mem_bus.rd_valid = 1'b0;
      since_trig = (hcount == 0) ? 0 : since_trig + 1;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          mem_bus.rd_valid = 1'b1;
          mem_bus.rd_data  = mem_arr[lat];
          busy = 0;
          delivered++;
        end
      end else if (stray_cnt > 0) begin
        stray_cnt--;
        mem_bus.rd_valid = 1'b1;
        mem_bus.rd_data  = 24'($urandom);
      end
      if (mem_bus.rd_req === 1'b1 && !RESET) begin
        req_cycles++;
        if (busy) begin
          // A restart right after a line trigger may legitimately overlap
          // the tail of an abandoned word.
          if (since_trig > 3) req_while_busy++;
        end else begin
          if (waitc > 0 && mem_bus.rd_addr !== prev_addr) addr_changes++;
          if (waitc >= ack_stall) begin
            mem_bus.rd_ack = 1'b1;
            busy  = 1;
            lat   = int'(mem_bus.rd_addr);
            vcnt  = 2;
            waitc = 0;
            ack_q.push_back(lat);
          end else begin
            waitc++;
          end
        end
        prev_addr = mem_bus.rd_addr;
      end else begin
        waitc = 0;
      end
    end
  end

  initial begin : watchdog
    #(20 * 80000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  // One pixel clock: apply counters and random syncs, advance, and compare
  // the pins against the prediction made for the previous cycle.
  task automatic drive_cycle(input int h, input int v);
    logic [2:0]  e_rgb;
    logic [23:0] wd;
    bit          e_chk;
    hcount = 11'(h);
    vcount = 10'(v);
    hs_in  = 1'($urandom_range(0, 1));
    vs_in  = 1'($urandom_range(0, 1));
    if (h < 800 && v < 600) begin
      e_chk = ref_valid[v % 2];
      wd    = ref_bank[v % 2][h / 8];
      e_rgb = 3'((wd >> (3 * (h % 8))) & 24'h7);
    end else begin
      e_chk = 1;
      e_rgb = 3'b000;
    end
    @(posedge CLOCK_50);
    #1;
    checks++;
    if ({VGA_HS, VGA_VS} !== {last_hs, last_vs} ||
        (last_chk && {VGA_RED, VGA_GREEN, VGA_BLUE} !== last_rgb)) begin
      failures++;
      $display("FAIL display h=%0d v=%0d: got rgb=%b hs=%b vs=%b, want rgb=%b hs=%b vs=%b",
               last_h, last_v, {VGA_RED, VGA_GREEN, VGA_BLUE}, VGA_HS, VGA_VS,
               last_chk ? last_rgb : 3'bxxx, last_hs, last_vs);
    end
    last_rgb = e_rgb; last_hs = hs_in; last_vs = vs_in; last_chk = e_chk;
    last_h = h; last_v = v;
  endtask

  // One full line at vcount=v; checks the fetch it should (or should not) start.
  task automatic run_line(input int v);
    int t, d0, r0, b0, a0, bad;
    t  = (v == 665) ? 0 : v + 1;
    ack_q.delete();
    d0 = delivered; r0 = req_cycles; b0 = req_while_busy; a0 = addr_changes;
    for (int h = 0; h < 1040; h++) drive_cycle(h, v);
    if (t < 600) begin
      bad = -1;
      for (int i = 0; i < ack_q.size() && i < 100; i++)
        if (bad < 0 && ack_q[i] != t * 100 + i) bad = i;
      checks++;
      if (ack_q.size() != 100 || delivered - d0 != 100 || bad >= 0) begin
        failures++;
        $display("FAIL fetch line=%0d: got %0d acks %0d beats first_bad=%0d, want 100 acks at %0d..%0d",
                 t, ack_q.size(), delivered - d0, bad, t * 100, t * 100 + 99);
      end
      for (int w = 0; w < 100; w++) ref_bank[t % 2][w] = mem_arr[t * 100 + w];
      ref_valid[t % 2] = 1;
      checks++;
      if (underrun !== 1'b0) begin
        failures++;
        $display("FAIL underrun_clear line=%0d: got %b, want 0", t, underrun);
      end
    end else begin
      checks++;
      if (req_cycles != r0) begin
        failures++;
        $display("FAIL no_fetch v=%0d: got %0d request cycles, want 0", v, req_cycles - r0);
      end
    end
    checks++;
    if (req_while_busy != b0 || addr_changes != a0) begin
      failures++;
      $display("FAIL handshake v=%0d: got %0d overlapping reqs %0d addr changes, want 0 0",
               v, req_while_busy - b0, addr_changes - a0);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hcount = 11'($urandom_range(0, 1039));
      vcount = 10'($urandom_range(0, 665));
      hs_in  = 1'($urandom_range(0, 1));
      vs_in  = 1'($urandom_range(0, 1));
      @(posedge CLOCK_50);
      #1;
      checks++;
      if (mem_bus.rd_req !== 1'b0 || mem_bus.rd_addr !== '0 || underrun !== 1'b0 ||
          {VGA_RED, VGA_GREEN, VGA_BLUE} !== 3'b000 || VGA_HS !== 1'b1 || VGA_VS !== 1'b1) begin
        failures++;
        $display("FAIL reset_state: got req=%b addr=%0d und=%b rgb=%b hs=%b vs=%b, want 0 0 0 000 1 1",
                 mem_bus.rd_req, mem_bus.rd_addr, underrun,
                 {VGA_RED, VGA_GREEN, VGA_BLUE}, VGA_HS, VGA_VS);
      end
    end
    RESET = 1'b0;
    last_rgb = 3'b000; last_hs = 1'b1; last_vs = 1'b1; last_chk = 1;
  endtask

  task automatic test_line_fetch();
    int v;
    run_line(0);
    run_line(1);
    for (int i = 0; i < 2; i++) begin
      v = $urandom_range(2, 597);
      run_line(v);
      run_line(v + 1);
    end
  endtask

  task automatic test_blanking();
    run_line(599);
    run_line($urandom_range(600, 664));
    run_line(665);
    run_line(0);
  endtask

  task automatic test_addr_hold();
    int v;
    ack_stall = 5;
    v = $urandom_range(1, 597);
    run_line(v);
    run_line(v + 1);
    ack_stall = 1;
  endtask

  task automatic test_reset_midfetch();
    int v, t;
    bit hit;
    v = 2 * $urandom_range(0, 290) + 1;
    t = v + 1;
    hit = 0;
    ack_q.delete();
    for (int h = 0; h < 1040 && !hit; h++) begin
      drive_cycle(h, v);
      if (mem_bus.rd_req === 1'b1 && mem_bus.rd_addr === 16'(t * 100 + 37)) hit = 1;
    end
    checks++;
    if (!hit || ack_q.size() != 37) begin
      failures++;
      $display("FAIL reset_point: got hit=%b acks=%0d, want hit=1 acks=37", hit, ack_q.size());
    end
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checks++;
    if (mem_bus.rd_req !== 1'b0 || mem_bus.rd_addr !== '0 || underrun !== 1'b0 ||
        {VGA_RED, VGA_GREEN, VGA_BLUE} !== 3'b000 || VGA_HS !== 1'b1 || VGA_VS !== 1'b1) begin
      failures++;
      $display("FAIL reset_midfetch: got req=%b addr=%0d und=%b rgb=%b hs=%b vs=%b, want 0 0 0 000 1 1",
               mem_bus.rd_req, mem_bus.rd_addr, underrun,
               {VGA_RED, VGA_GREEN, VGA_BLUE}, VGA_HS, VGA_VS);
    end
    RESET = 1'b0;
    stray_cnt = 2;
    last_rgb = 3'b000; last_hs = 1'b1; last_vs = 1'b1; last_chk = 1;
    for (int h = 200; h < 212; h++) drive_cycle(h, v);
    // Words 0..36 landed before reset; the rest of the bank is untouched.
    for (int w = 0; w < 37; w++) ref_bank[t % 2][w] = mem_arr[t * 100 + w];
    run_line(t);
    run_line(t + 1);
  endtask

  task automatic test_underrun();
    int v, b0;
    ack_stall = 20;
    v = $urandom_range(1, 590);
    ref_valid[0] = 0;
    ref_valid[1] = 0;
    ack_q.delete();
    b0 = req_while_busy;
    for (int h = 0; h < 1040; h++) drive_cycle(h, v);
    checks++;
    if (underrun !== 1'b0 || ack_q.size() == 0 || ack_q[0] != (v + 1) * 100) begin
      failures++;
      $display("FAIL slow_fetch_start: got und=%b acks=%0d first=%0d, want 0 >0 %0d",
               underrun, ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1, (v + 1) * 100);
    end
    ack_q.delete();
    drive_cycle(0, v + 1);
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_rise: got %b, want 1", underrun);
    end
    for (int h = 1; h < 1040; h++) drive_cycle(h, v + 1);
    while (ack_q.size() > 0 && ack_q[0] >= (v + 1) * 100 && ack_q[0] < (v + 2) * 100)
      void'(ack_q.pop_front());
    checks++;
    if (ack_q.size() == 0 || ack_q[0] != (v + 2) * 100) begin
      failures++;
      $display("FAIL restart_addr: got %0d, want %0d",
               (ack_q.size() > 0) ? ack_q[0] : -1, (v + 2) * 100);
    end
    checks++;
    if (underrun !== 1'b1 || req_while_busy != b0) begin
      failures++;
      $display("FAIL underrun_sticky: got und=%b overlaps=%0d, want 1 0",
               underrun, req_while_busy - b0);
    end
    ack_stall = 1;
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_reset: got %b, want 0", underrun);
    end
  endtask

  initial begin : main
    for (int i = 0; i < 60000; i++) mem_arr[i] = 24'($urandom);
    ref_valid[0] = 0;
    ref_valid[1] = 0;
    test_reset();
    test_line_fetch();
    test_blanking();
    test_addr_hold();
    test_reset_midfetch();
    test_underrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
